// File: rtl/ascon_ctrl_fsm.sv
// ============================================================================
// Module      : ascon_ctrl_fsm
// Description : Sequencing controller for the ASCON-AEAD128 permutation/XOR
//               datapath. Steps through initialisation, AD absorption,
//               plaintext absorption and finalisation, one round per clock.
//               Optional feature macro: ASCON_ABORT_EN (adds abort_i).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_ctrl_fsm #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 8
) (
  input  logic       clock_i,
  input  logic       resetb_i,
`ifdef ASCON_ABORT_EN
  input  logic       abort_i,
`endif
  input  logic       start_i,
  input  logic       ad_empty_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic       init_p_o,
  output logic [3:0] round_o,
  output logic       enable_p_o,
  output logic       enable_xor_b_o,
  output logic       key_add_b_o,
  output logic [1:0] enable_xor_e_o,
  output logic       data_sel_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  // First round index and last counter value for each permutation length
  localparam logic [3:0] BASE_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] BASE_B = 4'(12 - ROUNDS_B);
  localparam logic [3:0] LAST_A = 4'(ROUNDS_A - 1);
  localparam logic [3:0] LAST_B = 4'(ROUNDS_B - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_WAIT_AD = 3'd2,
    S_AD      = 3'd3,
    S_WAIT_PT = 3'd4,
    S_PT      = 3'd5,
    S_FINAL   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;
  logic       ad_empty_lat, next_ad_empty;
  logic       ad_last_lat, next_ad_last;

  // State, round counter and per-message flags
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      ad_empty_lat <= 1'b0;
      ad_last_lat  <= 1'b0;
    end else begin
      state        <= next_state;
      cnt          <= next_cnt;
      ad_empty_lat <= next_ad_empty;
      ad_last_lat  <= next_ad_last;
    end
  end

  // Next-state and datapath control decode; a WAIT-state transfer cycle is
  // already the first round of the block it brings in
  always_comb begin
    next_state     = state;
    next_cnt       = cnt;
    next_ad_empty  = ad_empty_lat;
    next_ad_last   = ad_last_lat;
    data_ready_o   = 1'b0;
    init_p_o       = 1'b0;
    round_o        = 4'd0;
    enable_p_o     = 1'b0;
    enable_xor_b_o = 1'b0;
    key_add_b_o    = 1'b0;
    enable_xor_e_o = 2'b00;
    data_sel_o     = 1'b0;
    cipher_valid_o = 1'b0;
    tag_valid_o    = 1'b0;
    busy_o         = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (start_i) begin
          next_state    = S_INIT;
          next_cnt      = 4'd0;
          next_ad_empty = ad_empty_i;
        end
      end

      S_INIT: begin
        enable_p_o = 1'b1;
        round_o    = BASE_A + cnt;
        init_p_o   = (cnt == 4'd0);
        if (cnt == LAST_A) begin
          enable_xor_e_o = ad_empty_lat ? 2'b11 : 2'b01;
          next_state     = ad_empty_lat ? S_WAIT_PT : S_WAIT_AD;
          next_cnt       = 4'd0;
        end else begin
          next_cnt = cnt + 4'd1;
        end
      end

      S_WAIT_AD: begin
        data_ready_o = 1'b1;
        data_sel_o   = 1'b0;
        if (data_valid_i) begin
          enable_p_o     = 1'b1;
          enable_xor_b_o = 1'b1;
          round_o        = BASE_B;
          next_ad_last   = data_last_i;
          if (LAST_B == 4'd0) begin
            // Single-round p^b: the transfer cycle is also the last round
            enable_xor_e_o = data_last_i ? 2'b10 : 2'b00;
            next_state     = data_last_i ? S_WAIT_PT : S_WAIT_AD;
            next_cnt       = 4'd0;
          end else begin
            next_state = S_AD;
            next_cnt   = 4'd1;
          end
        end
      end

      S_AD: begin
        enable_p_o = 1'b1;
        round_o    = BASE_B + cnt;
        if (cnt == LAST_B) begin
          enable_xor_e_o = ad_last_lat ? 2'b10 : 2'b00;
          next_state     = ad_last_lat ? S_WAIT_PT : S_WAIT_AD;
          next_cnt       = 4'd0;
        end else begin
          next_cnt = cnt + 4'd1;
        end
      end

      S_WAIT_PT: begin
        data_ready_o = 1'b1;
        data_sel_o   = 1'b1;
        if (data_valid_i) begin
          enable_p_o     = 1'b1;
          enable_xor_b_o = 1'b1;
          cipher_valid_o = 1'b1;
          if (data_last_i) begin
            // Last PT block enters finalisation directly with key add
            key_add_b_o = 1'b1;
            round_o     = BASE_A;
            if (LAST_A == 4'd0) begin
              enable_xor_e_o = 2'b01;
              next_state     = S_DONE;
              next_cnt       = 4'd0;
            end else begin
              next_state = S_FINAL;
              next_cnt   = 4'd1;
            end
          end else begin
            round_o = BASE_B;
            if (LAST_B == 4'd0) begin
              next_cnt = 4'd0;
            end else begin
              next_state = S_PT;
              next_cnt   = 4'd1;
            end
          end
        end
      end

      S_PT: begin
        enable_p_o = 1'b1;
        round_o    = BASE_B + cnt;
        if (cnt == LAST_B) begin
          next_state = S_WAIT_PT;
          next_cnt   = 4'd0;
        end else begin
          next_cnt = cnt + 4'd1;
        end
      end

      S_FINAL: begin
        enable_p_o = 1'b1;
        round_o    = BASE_A + cnt;
        if (cnt == LAST_A) begin
          enable_xor_e_o = 2'b01;
          next_state     = S_DONE;
          next_cnt       = 4'd0;
        end else begin
          next_cnt = cnt + 4'd1;
        end
      end

      S_DONE: begin
        tag_valid_o = 1'b1;
        next_state  = S_IDLE;
        next_cnt    = 4'd0;
      end

      default: begin
        next_state = S_IDLE;
        next_cnt   = 4'd0;
      end
    endcase

`ifdef ASCON_ABORT_EN
    // Abort drops the message: return to IDLE and never flag its tag
    if (abort_i && (state != S_IDLE)) begin
      next_state  = S_IDLE;
      next_cnt    = 4'd0;
      tag_valid_o = 1'b0;
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_ascon_ctrl_fsm.sv
// ============================================================================
// Module      : tb_ascon_ctrl_fsm
// Description : Directed self-checking bench for ascon_ctrl_fsm
//               (default ROUNDS_A=12, ROUNDS_B=8; ASCON_ABORT_EN optional).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascon_ctrl_fsm;

  logic       clk;
  logic       resetb;
  logic       start, ad_empty, data_valid, data_last;
`ifdef ASCON_ABORT_EN
  logic       abort;
`endif
  logic       data_ready, init_p, enable_p, enable_xor_b, key_add_b;
  logic       data_sel, cipher_valid, tag_valid, busy;
  logic [3:0] round;
  logic [1:0] enable_xor_e;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-run observations collected by run_msg
  int rnd [0:99];
  int tag_cyc, n_tag, n_init, n_ciph, n_x10, x10_cyc, x11_cyc, x01_cyc;
  int ka_cyc, last_busy, stall_en, stall_rdy;
  int ciph_cyc [0:3];

  ascon_ctrl_fsm dut (
    .clock_i       (clk),
    .resetb_i      (resetb),
`ifdef ASCON_ABORT_EN
    .abort_i       (abort),
`endif
    .start_i       (start),
    .ad_empty_i    (ad_empty),
    .data_valid_i  (data_valid),
    .data_last_i   (data_last),
    .data_ready_o  (data_ready),
    .init_p_o      (init_p),
    .round_o       (round),
    .enable_p_o    (enable_p),
    .enable_xor_b_o(enable_xor_b),
    .key_add_b_o   (key_add_b),
    .enable_xor_e_o(enable_xor_e),
    .data_sel_o    (data_sel),
    .cipher_valid_o(cipher_valid),
    .tag_valid_o   (tag_valid),
    .busy_o        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic [15:0] outs();
    return {data_ready, init_p, round, enable_p, enable_xor_b, key_add_b,
            enable_xor_e, data_sel, cipher_valid, tag_valid, busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    resetb = 1'b0; start = 1'b0; ad_empty = 1'b0; data_valid = 1'b0; data_last = 1'b0;
`ifdef ASCON_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) cyc();
    resetb = 1'b1;
    cyc();
  endtask

  // Start one message at cycle 0 and observe cycles 1..ncyc.
  // data_valid is low in [v_lo,v_hi]; data_last high on cycles last1/last2;
  // start re-pulsed on cycle start2.
  task automatic run_msg(input logic ade, input int v_lo, input int v_hi,
                         input int last1, input int last2, input int start2,
                         input int ncyc);
    tag_cyc = -1; n_tag = 0; n_init = 0; n_ciph = 0; n_x10 = 0; x10_cyc = -1;
    x11_cyc = -1; x01_cyc = -1; ka_cyc = -1; last_busy = -1; stall_en = 0; stall_rdy = 0;
    for (int i = 0; i < 4; i++) ciph_cyc[i] = -1;
    for (int i = 0; i < 100; i++) rnd[i] = -1;
    start = 1'b1; ad_empty = ade; data_valid = 1'b0; data_last = 1'b0;
    cyc();
    ad_empty = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      start      = (c == start2);
      data_valid = !(c >= v_lo && c <= v_hi);
      data_last  = (c == last1) || (c == last2);
      #1;
      rnd[c] = int'(round);
      if (tag_valid)    begin n_tag++; tag_cyc = c; end
      if (init_p)       n_init++;
      if (cipher_valid) begin
        if (n_ciph < 4) ciph_cyc[n_ciph] = c;
        n_ciph++;
      end
      if (enable_xor_e == 2'b10) begin n_x10++; x10_cyc = c; end
      if (enable_xor_e == 2'b11) x11_cyc = c;
      if (enable_xor_e == 2'b01) x01_cyc = c;
      if (key_add_b) ka_cyc = c;
      if (busy) last_busy = c;
      if (c >= v_lo && c <= v_hi) begin
        stall_en  += int'(enable_p);
        stall_rdy += int'(data_ready);
      end
      cyc();
    end
  endtask

  initial begin
    // 1: reset with start held, then first INIT cycle
    resetb = 1'b0; start = 1'b1; ad_empty = 1'b0; data_valid = 1'b1; data_last = 1'b1;
`ifdef ASCON_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) cyc();
    #1 check("rst_outs", 32'(outs()), 0);
    resetb = 1'b1;
    #1 check("idle_outs", 32'(outs()), 0);
    cyc();
    start = 1'b0;
    #1 check("start_busy", 32'(busy), 1);
    check("start_init_p", 32'(init_p), 1);
    cyc();
    #1 check("init_p_one_cycle", 32'(init_p), 0);
    do_reset();

    // 2: empty AD, one last PT block
    run_msg(1'b1, 0, -1, 13, -1, -1, 30);
    for (int i = 0; i < 12; i++) check("t2_init_round", 32'(rnd[1 + i]), 32'(i));
    check("t2_xor_e_11", 32'(x11_cyc), 12);
    check("t2_key_add", 32'(ka_cyc), 13);
    check("t2_n_cipher", 32'(n_ciph), 1);
    check("t2_cipher_cyc", 32'(ciph_cyc[0]), 13);
    for (int i = 0; i < 12; i++) check("t2_final_round", 32'(rnd[13 + i]), 32'(i));
    check("t2_final_xor_e", 32'(x01_cyc), 24);
    check("t2_tag_cyc", 32'(tag_cyc), 25);
    check("t2_n_tag", 32'(n_tag), 1);
    check("t2_last_busy", 32'(last_busy), 25);

    // 3: two AD blocks, two PT blocks, valid always high
    run_msg(1'b0, 0, -1, 21, 37, -1, 60);
    for (int i = 0; i < 8; i++) check("t3_ad_round", 32'(rnd[13 + i]), 32'(4 + i));
    check("t3_n_x10", 32'(n_x10), 1);
    check("t3_x10_cyc", 32'(x10_cyc), 28);
    check("t3_n_cipher", 32'(n_ciph), 2);
    check("t3_cipher0", 32'(ciph_cyc[0]), 29);
    check("t3_cipher1", 32'(ciph_cyc[1]), 37);
    check("t3_key_add", 32'(ka_cyc), 37);
    check("t3_final_x01", 32'(x01_cyc), 48);
    check("t3_tag_cyc", 32'(tag_cyc), 49);
    check("t3_last_busy", 32'(last_busy), 49);

    // 4: valid withheld 5 cycles in WAIT_AD
    run_msg(1'b0, 13, 17, 18, 26, -1, 50);
    check("t4_stall_en", 32'(stall_en), 0);
    check("t4_stall_rdy", 32'(stall_rdy), 5);
    check("t4_stall_round", 32'(rnd[17]), 0);
    check("t4_ad_first_round", 32'(rnd[18]), 4);
    check("t4_x10_cyc", 32'(x10_cyc), 25);
    check("t4_tag_cyc", 32'(tag_cyc), 38);

    // 5: start pulsed during FINAL is ignored
    run_msg(1'b1, 0, -1, 13, -1, 20, 40);
    check("t5_n_init", 32'(n_init), 1);
    check("t5_n_tag", 32'(n_tag), 1);
    check("t5_tag_cyc", 32'(tag_cyc), 25);
    check("t5_last_busy", 32'(last_busy), 25);

    // 6: asynchronous reset in AD round 6
    start = 1'b1; ad_empty = 1'b0; data_valid = 1'b1; data_last = 1'b0;
    cyc();
    start = 1'b0;
    repeat (18) cyc();
    #1 check("t6_ad_round6", 32'(round), 10);
    check("t6_ad_enable_p", 32'(enable_p), 1);
    #1 resetb = 1'b0;
    #1 check("t6_async_outs", 32'(outs()), 0);
    cyc();
    resetb = 1'b1;
    data_valid = 1'b0;
    cyc();
    #1 check("t6_idle_after", 32'(outs()), 0);

`ifdef ASCON_ABORT_EN
    // Abort during a non-last PT block
    do_reset();
    start = 1'b1; ad_empty = 1'b1; data_valid = 1'b1; data_last = 1'b0;
    cyc();
    start = 1'b0; ad_empty = 1'b0;
    repeat (13) cyc();
    abort = 1'b1;
    #1 check("ab_busy_before", 32'(busy), 1);
    cyc();
    abort = 1'b0;
    #1 check("ab_outs_after", 32'(outs()), 0);
    n_tag = 0;
    for (int c = 0; c < 30; c++) begin
      if (tag_valid) n_tag++;
      cyc();
    end
    check("ab_no_tag", 32'(n_tag), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ascon_ctrl_fsm.md
Name: ascon_ctrl_fsm

Overview:
Sequencing controller for the ASCON-AEAD128 permutation/XOR datapath (state mux, Xor_Begin, Pc/Ps/Pl, Xor_End, state register). It steps the datapath through one encryption:
- initialisation
- associated data (AD) absorption
- plaintext absorption
- finalisation and tag release

It drives every datapath control: init, round index, register enable, begin/end XOR enables and key-add. It also handshakes AD/PT blocks with the top level. One permutation round per clock.

Parameters:
ROUNDS_A, 12, rounds of p^a (initialisation, finalisation); legal values 1..12
ROUNDS_B, 8, rounds of p^b (AD and non-last PT blocks); legal values 1..12

Ports:
clock_i  in  1  system clock, rising edge
resetb_i  in  1  asynchronous reset, active low
start_i  in  1  start one encryption; sampled in IDLE only
ad_empty_i  in  1  no AD for this message; sampled with start_i
data_valid_i  in  1  AD/PT block present on top-level data bus
data_last_i  in  1  current block is last of its kind (AD or PT)
data_ready_o  out  1  controller accepts a block this cycle
init_p_o  out  1  state mux selects external initial state (IV||K||N)
round_o  out  4  round constant index to Pc
enable_p_o  out  1  state register enable
enable_xor_b_o  out  1  XOR data block into rate before round
key_add_b_o  out  1  XOR key into S2||S3 before round (finalisation entry)
enable_xor_e_o  out  2  00 none, 01 key into S3||S4, 10 domain-sep bit into S4 LSB, 11 both
data_sel_o  out  1  0 = AD block, 1 = PT block on Xor_Begin data
cipher_valid_o  out  1  ciphertext (rate XOR PT) valid this cycle
tag_valid_o  out  1  tag in state S3||S4 valid
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (resetb_i=0, asynchronous): state IDLE, round counter 0, all outputs 0. Reset mid-operation aborts immediately; no partial result is flagged.
- States: IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE.
- Round counter cnt runs 0..R-1, with R = ROUNDS_A or ROUNDS_B.
- round_o = 12 - R + cnt. So p^12 gives 0..11 and p^8 gives 4..11.
- enable_p_o = 1 on every cycle of INIT/AD/PT/FINAL, else 0.
- IDLE:
  - start_i=1 latches ad_empty_i and moves to INIT with cnt=0.
  - init_p_o=1 only on the first INIT cycle.
- INIT: ROUNDS_A cycles.
  - On the last cycle enable_xor_e_o=01, or 11 if ad_empty latched.
  - Next state: WAIT_PT if ad_empty, else WAIT_AD.
- WAIT_AD / WAIT_PT:
  - data_ready_o=1; data_sel_o = 0 in WAIT_AD, 1 in WAIT_PT.
  - Transfer occurs when data_valid_i & data_ready_o.
  - data_valid_i outside these states is ignored.
- AD (entered on a WAIT_AD transfer; the transfer cycle is the first round):
  - enable_xor_b_o=1 on cnt=0 only; ROUNDS_B rounds.
  - On the last round, if the block is last, enable_xor_e_o=10 and next state is WAIT_PT.
  - Otherwise next state is WAIT_AD.
- PT, non-last block:
  - cipher_valid_o=1 on the transfer cycle, enable_xor_b_o=1 on cnt=0; ROUNDS_B rounds, then WAIT_PT.
- PT, last block: go directly to FINAL.
  - The transfer cycle is FINAL cnt=0, with enable_xor_b_o=1, key_add_b_o=1 and cipher_valid_o=1.
- FINAL: ROUNDS_A rounds.
  - On the last round enable_xor_e_o=01; then DONE.
- DONE:
  - tag_valid_o=1 for exactly one cycle, then IDLE.
  - start_i in DONE is ignored; it must be re-asserted in IDLE.
- start_i while busy_o=1 is ignored.
- data_last_i is sampled only on a transfer.
- An empty PT message is not supported: at least one PT block, the last one, is mandatory.
- Control outputs are registered-state decodes (Moore) except data_ready_o-qualified strobes, which are combinational from data_valid_i. No combinational path exists from inputs to enable_p_o outside WAIT states.

Optional Feature:
ASCON_ABORT_EN:
- When defined, adds input abort_i (1 bit).
- abort_i=1 in any state other than IDLE forces IDLE on the next edge.
- All strobes are low from that edge onward, and tag_valid_o is never raised for that message.
- When undefined, there is no abort_i port and only reset aborts.

Test Plan:
1. Reset with start_i=1 held: all outputs 0 while resetb_i=0; after release, start_i in IDLE causes busy_o=1 next cycle and init_p_o=1 for 1 cycle.
2. ad_empty_i=1, one last PT block presented immediately:
   - INIT shows round_o 0..11 and enable_xor_e_o=11 at round 11.
   - PT accepted with cipher_valid_o=1 and key_add_b_o=1.
   - FINAL shows round_o 0..11; tag_valid_o pulses 25 cycles after start acceptance.
3. 2 AD blocks plus 2 PT blocks, valid always high:
   - AD rounds show round_o 4..11.
   - enable_xor_e_o=10 only at the end of the second AD block.
   - cipher_valid_o pulses twice; tag_valid_o at cycle 12+8+8+8+12+1=49.
4. data_valid_i withheld 5 cycles in WAIT_AD: enable_p_o=0 and state is held; the register is not updated during the stall.
5. start_i pulsed during FINAL: ignored; no second INIT, and busy_o drops after DONE.
6. resetb_i asserted mid-AD round 6: outputs go to 0 asynchronously, without waiting for a clock edge; IDLE after release.
   - With ASCON_ABORT_EN: abort_i in PT returns to IDLE with no tag_valid_o.
